// File: rtl/cordic_unit.sv
// Iterative CORDIC engine: rotation or vectoring per transaction, valid/ready on both sides.
// Define CORDIC_QUAD_CORRECT_EN to pre-rotate operands by pi at accept for full-circle convergence.
module cordic_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    mode_out
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned IW = $clog2(ITER);

  function automatic real scale_f();
    real s;
    s = 1.0;
    for (int k = 0; k < int'(WIDTH) - 3; k++) s = s * 2.0;
    return s;
  endfunction

  localparam real Scale = scale_f();
  localparam real Pi    = 3.14159265358979323846;

  // atan(2^-idx) in angle LSBs; Taylor series for idx >= 1 (argument <= 0.5).
  function automatic int atan_lsb(int idx);
    real t, p, s;
    if (idx == 0) begin
      s = Pi / 4.0;
    end else begin
      t = 1.0;
      for (int k = 0; k < idx; k++) t = t / 2.0;
      s = 0.0;
      p = t;
      for (int k = 0; k < 40; k++) begin
        if (k % 2 == 0) s = s + p / real'(2 * k + 1);
        else            s = s - p / real'(2 * k + 1);
        p = p * t * t;
      end
    end
    return $rtoi(s * Scale + 0.5);
  endfunction

  // Symmetric clamp; an in-range -2^(WIDTH-1) passes through unchanged.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v[XW-1:WIDTH-1] == {3{v[XW-1]}}) return v[WIDTH-1:0];
    else if (v[XW-1])                    return {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    else                                 return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic signed [WIDTH-1:0] atan_tab [ITER];

  for (genvar g = 0; g < int'(ITER); g++) begin : g_atan
    localparam int AtanVal = atan_lsb(g);
    assign atan_tab[g] = WIDTH'(AtanVal);
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic                    mode_q, mode_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                    in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic signed [XW-1:0]    x_init, y_init, x_nxt, y_nxt, x_sh, y_sh;
  logic signed [WIDTH-1:0] z_init, z_nxt;
  logic                    sigma_pos;

`ifdef CORDIC_QUAD_CORRECT_EN
  localparam logic signed [WIDTH-1:0] PiLsb     = WIDTH'($rtoi(Pi * Scale + 0.5));
  localparam logic signed [WIDTH-1:0] HalfPiLsb = WIDTH'($rtoi(Pi / 2.0 * Scale + 0.5));

  always_comb begin
    x_init = {{2{x_in[WIDTH-1]}}, x_in};
    y_init = {{2{y_in[WIDTH-1]}}, y_in};
    z_init = in_mode ? '0 : z_in;
    if (in_mode) begin
      if (x_in < 0) begin
        x_init = -x_init;
        y_init = -y_init;
        z_init = (y_in >= 0) ? PiLsb : -PiLsb;
      end
    end else if (z_in > HalfPiLsb || z_in < -HalfPiLsb) begin
      x_init = -x_init;
      y_init = -y_init;
      z_init = (z_in > 0) ? z_in - PiLsb : z_in + PiLsb;
    end
  end
`else
  always_comb begin
    x_init = {{2{x_in[WIDTH-1]}}, x_in};
    y_init = {{2{y_in[WIDTH-1]}}, y_in};
    z_init = in_mode ? '0 : z_in;
  end
`endif

  always_comb begin
    sigma_pos = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    x_nxt     = sigma_pos ? x_q - y_sh : x_q + y_sh;
    y_nxt     = sigma_pos ? y_q + x_sh : y_q - x_sh;
    z_nxt     = sigma_pos ? z_q - atan_tab[iter_q] : z_q + atan_tab[iter_q];
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    mode_d    = mode_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    z_out_d   = z_out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = x_init;
          y_d     = y_init;
          z_d     = z_init;
          mode_d  = in_mode;
          iter_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        x_d    = x_nxt;
        y_d    = y_nxt;
        z_d    = z_nxt;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(ITER - 1)) begin
          iter_d  = '0;
          x_out_d = sat(x_nxt);
          y_out_d = sat(y_nxt);
          z_out_d = z_nxt;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mode_q      <= mode_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_out_q     <= z_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;
  assign mode_out  = mode_q;

endmodule

// File: tb/tb_cordic_unit.sv
// Directed bench for cordic_unit: ideal-math scoreboard with tolerances, handshake timing,
// back-pressure, mid-transaction reset and saturation.
module tb_cordic_unit;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ITER  = 16;
  localparam real         SCALE = 8192.0;

  logic                    Clk = 1'b0;
  logic                    Rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    in_mode = 1'b0;
  logic signed [WIDTH-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] x_out, y_out, z_out;
  logic                    mode_out;

  typedef struct {
    string tag;
    bit    mode;
    int    x, y, z, txy, tz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  real  k_gain;

  cordic_unit #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .mode_out (mode_out)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int rnd(real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(-r + 0.5);
  endfunction

  function automatic int sat16(int v);
    if (v > 32767)  return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  task automatic chk(string tag, int obs, int expv, int tol);
    n_vec++;
    assert ((obs - expv <= tol) && (expv - obs <= tol))
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  task automatic chk_bit(string tag, logic obs, logic expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(string tag, bit m, int x, int y, int z, int txy, int tz);
    exp_t e;
    real  a;
    e.tag  = tag;
    e.mode = m;
    e.txy  = txy;
    e.tz   = tz;
    if (m) begin
      e.x = sat16(rnd(k_gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y))));
      e.y = 0;
      e.z = rnd($atan2(real'(y), real'(x)) * SCALE);
    end else begin
      a   = real'(z) / SCALE;
      e.x = sat16(rnd(k_gain * (real'(x) * $cos(a) - real'(y) * $sin(a))));
      e.y = sat16(rnd(k_gain * (real'(x) * $sin(a) + real'(y) * $cos(a))));
      e.z = 0;
    end
    return e;
  endfunction

  task automatic send(string tag, bit m, int x, int y, int z, int txy, int tz);
    chk_bit({tag, " in_ready before accept"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_mode  = m;
    x_in     = WIDTH'(x);
    y_in     = WIDTH'(y);
    z_in     = WIDTH'(z);
    sb.push_back(model(tag, m, x, y, z, txy, tz));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, int'(ITER), 0);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb[0];
      chk_bit({e.tag, " mode_out"}, mode_out, e.mode);
      chk({e.tag, " x_out"}, int'(x_out), e.x, e.txy);
      chk({e.tag, " y_out"}, int'(y_out), e.y, e.txy);
      chk({e.tag, " z_out"}, int'(z_out), e.z, e.tz);
    end
  endtask

  task automatic release_out(string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_bit({tag, " out_valid after release"}, out_valid, 1'b0);
    chk_bit({tag, " in_ready after release"}, in_ready, 1'b1);
  endtask

  task automatic run(string tag, bit m, int x, int y, int z, int txy, int tz);
    send(tag, m, x, y, z, txy, tz);
    wait_done(tag);
    check_front();
    void'(sb.pop_front());
    release_out(tag);
  endtask

  initial begin
    int vx, vy, vz;
    k_gain = 1.0;
    for (int i = 0; i < int'(ITER); i++) k_gain = k_gain * $sqrt(1.0 + 1.0 / real'(4 ** i));

    // Reset state
    repeat (3) tick();
    Rst = 1'b0;
    chk_bit("reset in_ready", in_ready, 1'b1);
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_bit("reset mode_out", mode_out, 1'b0);
    chk("reset x_out", int'(x_out), 0, 0);
    chk("reset y_out", int'(y_out), 0, 0);
    chk("reset z_out", int'(z_out), 0, 0);
    tick();

    // Vectoring 45 degrees, with busy-state in_ready check
    send("vec45", 1'b1, 8192, 8192, 0, 8, 4);
    chk_bit("vec45 in_ready while busy", in_ready, 1'b0);
    wait_done("vec45");
    check_front();
    void'(sb.pop_front());
    release_out("vec45");

    run("rot45", 1'b0, 9949, 0, 6434, 8, 4);
    run("sat", 1'b0, 32767, 32767, 0, 0, 4);

    for (int i = 0; i < 6; i++) begin
      vx = int'($urandom_range(12000, 2000));
      vy = int'($urandom_range(24000, 0)) - 12000;
      run("vec_rand", 1'b1, vx, vy, 0, 32, 8);
    end
    for (int i = 0; i < 6; i++) begin
      vx = int'($urandom_range(24000, 0)) - 12000;
      vy = int'($urandom_range(24000, 0)) - 12000;
      vz = int'($urandom_range(24000, 0)) - 12000;
      run("rot_rand", 1'b0, vx, vy, vz, 32, 8);
    end

`ifdef CORDIC_QUAD_CORRECT_EN
    run("quad_pos", 1'b1, -8192, 1, 0, 8, 4);
    run("quad_neg", 1'b1, -8192, -1, 0, 8, 4);
    run("quad_rot", 1'b0, 8192, 3000, 20000, 32, 8);
    run("quad_rotn", 1'b0, -6000, 5000, -22000, 32, 8);
`endif

    // Back-pressure: hold DONE with out_ready low; in_valid pulses must be ignored
    send("bp", 1'b0, 5000, -3000, -4000, 32, 8);
    wait_done("bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_mode  = 1'b1;
      x_in     = 16'sd1234;
      y_in     = -16'sd777;
      tick();
      chk_bit("bp out_valid held", out_valid, 1'b1);
      chk_bit("bp in_ready low", in_ready, 1'b0);
      check_front();
    end
    in_valid = 1'b0;
    void'(sb.pop_front());
    release_out("bp");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_bit("bp no ghost txn", out_valid, 1'b0);
    end

    // Reset during iteration 7 abandons the transaction
    send("rst", 1'b1, 7000, 2000, 0, 8, 4);
    repeat (7) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    void'(sb.pop_back());
    chk_bit("rst out_valid", out_valid, 1'b0);
    chk_bit("rst in_ready", in_ready, 1'b1);
    chk_bit("rst mode_out", mode_out, 1'b0);
    chk("rst x_out", int'(x_out), 0, 0);
    chk("rst y_out", int'(y_out), 0, 0);
    chk("rst z_out", int'(z_out), 0, 0);
    run("after_rst", 1'b1, 7000, 2000, 0, 16, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cordic_unit.md
# cordic_unit

Iterative, parametrised CORDIC engine that runs either rotation mode (rotate vector (x, y) by angle z) or vectoring mode (magnitude and atan2 of (x, y)), selected per transaction. It replaces the fixed 16-bit vectoring-only engine in the math subsystem. Input and output use valid/ready handshakes so it can sit between streaming blocks with back-pressure. Optional quadrant pre-correction extends the convergence range to the full ±π circle.

## Interface
- WIDTH, 16: data/angle word width (8..32)
- ITER, 16: micro-rotations per transaction (4..WIDTH)
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- in_mode  in  1  0 = rotation, 1 = vectoring
- x_in, y_in  in  WIDTH  signed vector components
- z_in  in  WIDTH  signed start angle; rotation mode only, ignored in vectoring mode (start angle 0)
- out_valid  out  1  results present
- out_ready  in  1  consumer accepts results
- x_out, y_out, z_out  out  WIDTH  signed results, held stable while out_valid=1
- mode_out  out  1  in_mode of the transaction being presented

## Operation
- Angle format: signed, 1 LSB = 2^-(WIDTH-3) rad; π = round(π·2^(WIDTH-3)) (25736 at WIDTH=16).
- atan table: atan(2^-i)·2^(WIDTH-3), rounded, computed at elaboration for i = 0..ITER-1; no hand-entered constants.
- Internal x/y datapath is WIDTH+2 bits (2 guard bits); z is WIDTH bits.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: in_valid=1 -> latch operands and mode, clear i to 0, go BUSY.
- BUSY, per cycle: sigma = +1 if (rotation and z≥0) or (vectoring and y<0), else -1. Update x' = x - sigma·(y>>>i), y' = y + sigma·(x>>>i), z' = z - sigma·atan[i]; shifts are arithmetic. i increments; after iteration i = ITER-1, go DONE.
- DONE: outputs held; out_ready=1 -> go IDLE. out_ready is ignored in IDLE and BUSY.
- Output: x/y saturated from WIDTH+2 to WIDTH bits (clamp to ±max, -2^(WIDTH-1) allowed). No CORDIC gain compensation: magnitude outputs carry K ≈ 1.6468.
- Ideal results: vectoring gives x_out = K·√(x²+y²), y_out ≈ 0, z_out = atan2(y, x). Rotation gives (x_out, y_out) = K·R(z)(x, y), z_out ≈ 0.
- in_valid while not IDLE: ignored; the operands are not captured.
- Reset mid-transaction: the operation is abandoned. Next cycle is IDLE with no stale out_valid.

## Timing
- Reset values: in_ready=1 after reset deasserts, out_valid=0, x_out=y_out=z_out=0, mode_out=0, i=0.
- Accept edge T0 (in_valid & in_ready). Iterations happen on edges T1..T_ITER. out_valid is high from T_ITER, i.e. ITER cycles after acceptance.
- Minimum spacing between accepted transactions: ITER+2 cycles (out_ready held high).
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- CORDIC_QUAD_CORRECT_EN defined: correction is applied at the accept edge.
  - Vectoring with x_in<0: x=-x_in, y=-y_in; z0=+π if y_in≥0, else -π.
  - Rotation with |z_in|>π/2: x=-x_in, y=-y_in; z0 = z_in - π if z_in>0, else z_in + π.
  - Result: the full circle converges.
- Undefined: no pre-rotation. Convergence only for vectoring x_in≥0 and rotation |z_in| ≤ ~1.74 rad. Results outside that range are unspecified but still delivered with normal timing.

## Test plan
- Vectoring, WIDTH=16/ITER=16, x=8192, y=8192 -> z_out=6434±4, x_out=19078±8, y_out=0±4, out_valid exactly 16 cycles after accept.
- Rotation, x=9949, y=0, z=6434 -> x_out=11585±8, y_out=11585±8, z_out=0±4.
- With CORDIC_QUAD_CORRECT_EN: vectoring x=-8192, y=1 -> z_out=25736±4, x_out=13491±8. Also x=-8192, y=-1 -> z_out=-25736±4.
- Back-pressure: out_ready low 5 cycles in DONE -> outputs and out_valid stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Rst asserted at iteration 7 -> next cycle out_valid=0, outputs 0, in_ready=1. A following transaction completes with correct results.
- Saturation: rotation x=32767, y=32767, z=0 -> x_out=32767, y_out=32767 (clamped), no wrap to negative.
